// File: rtl/sarray_spad_master.sv
// Systolic-array scratchpad initiator: tile loads through a credit FIFO,
// tile stores forwarded straight onto the spad write channel.
module sarray_spad_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LOAD_WIDTH  = 2048,
  parameter int STORE_WIDTH = 2048,
  parameter int LEN_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]   cmd_len_i,
  output logic                   done_o,
  output logic                   ld_valid_o,
  input  logic                   ld_ready_i,
  output logic [LOAD_WIDTH-1:0]  ld_data_o,
  input  logic                   st_valid_i,
  output logic                   st_ready_o,
  input  logic [STORE_WIDTH-1:0] st_data_i,
  output logic                   sarray_ar_valid_o,
  input  logic                   sarray_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]  sarray_ar_addr_o,
  input  logic                   sarray_r_valid_i,
  output logic                   sarray_r_ready_o,
  input  logic [LOAD_WIDTH-1:0]  sarray_r_data_i,
  output logic                   sarray_aw_valid_o,
  input  logic                   sarray_aw_ready_i,
  output logic [ADDR_WIDTH-1:0]  sarray_aw_addr_o,
  output logic [STORE_WIDTH-1:0] sarray_aw_data_o,
  output logic                   err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = LEN_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, LD, LD_DRAIN, ST, FIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [NW-1:0]         len_q, len_d;
  logic [NW-1:0]         issued_q, issued_d;
  logic [NW-1:0]         beat_q, beat_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic                  ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  err_q, err_d;
  logic [LOAD_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic          ar_fire, aw_fire, st_act;
  logic          full, push, pop, r_dec;
  logic [CW:0]   credit;

  assign ar_fire = ar_valid_q & sarray_ar_ready_i;
  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign pop     = (cnt_q != '0) & ld_ready_i;
  assign push    = sarray_r_valid_i & (~full | pop);
  assign r_dec   = sarray_r_valid_i & (out_q != '0);
  assign st_act  = (state_q == ST) & (beat_q < len_q);
  assign aw_fire = st_act & st_valid_i & sarray_aw_ready_i;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q + NW'(ar_fire);
    beat_d     = beat_q + NW'(aw_fire);
    out_d      = out_q + CW'(ar_fire) - CW'(r_dec);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + PW'(push);
    rd_d       = rd_q + PW'(pop);
    err_d      = err_q | (sarray_r_valid_i & ~push);
    ar_valid_d = ar_valid_q & ~sarray_ar_ready_i;
    ar_addr_d  = ar_addr_q;
    unique case (state_q)
      IDLE: if (cmd_valid_i) begin
        base_d   = cmd_addr_i;
        len_d    = NW'(cmd_len_i);
        issued_d = '0;
        beat_d   = '0;
        state_d  = cmd_op_i ? ST : LD;
      end
      // zero-length commands spend one cycle here before finishing
      LD: begin
        if (len_q == '0)
          state_d = FIN;
        else if (ar_fire && issued_d == len_q)
          state_d = LD_DRAIN;
      end
      LD_DRAIN: if (out_q == '0 && cnt_q == '0)
        state_d = FIN;
      ST: if (len_q == '0 || (aw_fire && beat_d == len_q))
        state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // credit covers rows in flight plus rows buffered
    credit = (CW+1)'(cnt_d) + (CW+1)'(out_d);
    if (state_d == LD && !ar_valid_d && issued_d < len_d &&
        credit < (CW+1)'(FIFO_DEPTH)) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = base_d + ADDR_WIDTH'(issued_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beat_q     <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      beat_q     <= beat_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= sarray_r_data_i;
    end
  end

  assign cmd_ready_o       = state_q == IDLE;
  assign done_o            = state_q == FIN;
  assign ld_valid_o        = cnt_q != '0;
  assign ld_data_o         = mem_q[rd_q];
  assign sarray_r_ready_o  = 1'b1;
  assign sarray_ar_valid_o = ar_valid_q;
  assign sarray_ar_addr_o  = ar_addr_q;
  assign sarray_aw_valid_o = st_act & st_valid_i;
  assign st_ready_o        = st_act & sarray_aw_ready_i;
  assign sarray_aw_addr_o  = base_q + ADDR_WIDTH'(beat_q);
  assign sarray_aw_data_o  = st_act ? st_data_i : '0;
  assign err_o             = err_q;

endmodule

// File: tb/tb_sarray_spad_master.sv
// Bench for sarray_spad_master: spad responder, monitor and
// queue-based reference of expected addresses and rows.
module tb_sarray_spad_master;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int SW = 128;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_i = 0, cmd_ready_o, cmd_op_i = 0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [15:0]   cmd_len_i = '0;
  logic          done_o, ld_valid_o, ld_ready_i = 0;
  logic [LW-1:0] ld_data_o;
  logic          st_valid_i = 0, st_ready_o;
  logic [SW-1:0] st_data_i = '0;
  logic          ar_valid_o, ar_ready_i = 0;
  logic [AW-1:0] ar_addr_o;
  logic          r_valid_i = 0, r_ready_o;
  logic [LW-1:0] r_data_i = '0;
  logic          aw_valid_o, aw_ready_i = 1;
  logic [AW-1:0] aw_addr_o;
  logic [SW-1:0] aw_data_o;
  logic          err_o;

  always #5 clk = ~clk;

  sarray_spad_master #(
    .ADDR_WIDTH(AW), .LOAD_WIDTH(LW), .STORE_WIDTH(SW),
    .LEN_WIDTH(16), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i),
    .cmd_len_i(cmd_len_i), .done_o(done_o),
    .ld_valid_o(ld_valid_o), .ld_ready_i(ld_ready_i),
    .ld_data_o(ld_data_o),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_data_i(st_data_i),
    .sarray_ar_valid_o(ar_valid_o), .sarray_ar_ready_i(ar_ready_i),
    .sarray_ar_addr_o(ar_addr_o),
    .sarray_r_valid_i(r_valid_i), .sarray_r_ready_o(r_ready_o),
    .sarray_r_data_i(r_data_i),
    .sarray_aw_valid_o(aw_valid_o), .sarray_aw_ready_i(aw_ready_i),
    .sarray_aw_addr_o(aw_addr_o), .sarray_aw_data_o(aw_data_o),
    .err_o(err_o)
  );

  int n_pass = 0;
  int n_chk  = 0;

  function automatic logic [LW-1:0] row(input logic [AW-1:0] a);
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++)
      v[i*32 +: 32] = (a * 32'h9E3779B1) ^ (32'(i) << 24) ^ 32'h5A00_0000;
    return v;
  endfunction

  function automatic logic [SW-1:0] rnd_w();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++)
      v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // spad responder: in-order returns, one per cycle, latency >= 1
  typedef struct { logic [AW-1:0] a; int due; } rd_t;
  rd_t rq[$];
  rd_t ne;
  int  scyc = 0;
  int  lat_min = 2, lat_max = 2;
  bit  ar_rand = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rq.delete();
      r_valid_i  = 0;
      ar_ready_i = 0;
    end else begin
      scyc++;
      if (rq.size() > 0 && rq[0].due <= scyc) begin
        r_valid_i = 1;
        r_data_i  = row(rq[0].a);
        void'(rq.pop_front());
      end else begin
        r_valid_i = 0;
        r_data_i  = '0;
      end
      ar_ready_i = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ar_valid_o && ar_ready_i) begin
        ne.a   = ar_addr_o;
        ne.due = scyc + $urandom_range(lat_min, lat_max);
        if (rq.size() > 0 && ne.due <= rq[$].due)
          ne.due = rq[$].due + 1;
        rq.push_back(ne);
      end
    end
  end

  int ld_mode = 0;
  always @(negedge clk) begin
    case (ld_mode)
      0:       ld_ready_i = 1;
      1:       ld_ready_i = 0;
      default: ld_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor, sampled mid-cycle after all drivers settle
  logic [AW-1:0] ar_obs[$];
  logic [LW-1:0] ld_obs[$];
  logic [AW-1:0] awa_obs[$];
  logic [SW-1:0] awd_obs[$];
  int hs_q[$];
  int done_q[$];
  int mcyc = 0, done_cnt = 0, infl = 0, max_infl = 0;
  int stab_err = 0, last_aw = 0, epoch = 0, seen_ep = 0;
  logic pend_v = 0;
  logic [AW-1:0] pend_a = '0;
  always @(negedge clk) begin
    #3;
    mcyc++;
    if (epoch != seen_ep) begin
      max_infl = infl;
      seen_ep  = epoch;
    end
    if (!rst_n) begin
      pend_v = 0;
      infl   = 0;
    end else begin
      if (pend_v && !(ar_valid_o && ar_addr_o == pend_a))
        stab_err++;
      pend_v = ar_valid_o && !ar_ready_i;
      pend_a = ar_addr_o;
      if (ar_valid_o && ar_ready_i) begin
        ar_obs.push_back(ar_addr_o);
        infl++;
      end
      if (ld_valid_o && ld_ready_i) begin
        ld_obs.push_back(ld_data_o);
        infl--;
      end
      if (infl > max_infl) max_infl = infl;
      if (aw_valid_o && aw_ready_i) begin
        awa_obs.push_back(aw_addr_o);
        awd_obs.push_back(aw_data_o);
        last_aw = mcyc;
      end
      if (cmd_valid_i && cmd_ready_o) hs_q.push_back(mcyc);
      if (done_o) begin
        done_cnt++;
        done_q.push_back(mcyc);
      end
    end
  end

  task automatic send_cmd(input bit op, input logic [AW-1:0] a,
                          input int n);
    int t = 0;
    @(negedge clk);
    cmd_valid_i = 1;
    cmd_op_i    = op;
    cmd_addr_i  = a;
    cmd_len_i   = 16'(n);
    #1;
    while (!cmd_ready_o && t < 500) begin
      @(negedge clk); #1; t++;
    end
    @(negedge clk);
    cmd_valid_i = 0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk); t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #2;
    n_chk++;
    if (cmd_ready_o !== 1'b1 || r_ready_o !== 1'b1)
      $display("FAIL reset_ready got cmd=%b r=%b want 1 1",
               cmd_ready_o, r_ready_o);
    else n_pass++;
    n_chk++;
    if ({done_o, ld_valid_o, ar_valid_o, aw_valid_o, st_ready_o, err_o}
        !== 6'b0)
      $display("FAIL reset_ctl got %b want 000000",
               {done_o, ld_valid_o, ar_valid_o, aw_valid_o,
                st_ready_o, err_o});
    else n_pass++;
    n_chk++;
    if (ar_addr_o !== '0 || aw_addr_o !== '0 || ld_data_o !== '0)
      $display("FAIL reset_data got ar=%h aw=%h ld=%h want 0",
               ar_addr_o, aw_addr_o, ld_data_o);
    else n_pass++;
  endtask

  task automatic test_load(input string nm, input logic [AW-1:0] base,
                           input int n, input int lmin, input int lmax,
                           input bit arr, input int ldm);
    int a0, l0, d0, s0, bad;
    lat_min = lmin; lat_max = lmax; ar_rand = arr; ld_mode = ldm;
    epoch++;
    a0 = ar_obs.size(); l0 = ld_obs.size();
    d0 = done_cnt; s0 = stab_err;
    send_cmd(0, base, n);
    wait_done(d0);
    n_chk++;
    if (done_cnt - d0 != 1)
      $display("FAIL %s_done got %0d pulses want 1", nm, done_cnt - d0);
    else n_pass++;
    bad = -1;
    if (ar_obs.size() - a0 != n) bad = n;
    else for (int i = n - 1; i >= 0; i--)
      if (ar_obs[a0+i] !== base + 32'(i)) bad = i;
    n_chk++;
    if (bad >= 0)
      $display("FAIL %s_ar got %0d addrs (idx %0d) want %0d from %h",
               nm, ar_obs.size() - a0, bad, n, base);
    else n_pass++;
    bad = -1;
    if (ld_obs.size() - l0 != n) bad = n;
    else for (int i = n - 1; i >= 0; i--)
      if (ld_obs[l0+i] !== row(base + 32'(i))) bad = i;
    n_chk++;
    if (bad >= 0)
      $display("FAIL %s_rows got %0d rows (bad idx %0d) want %0d",
               nm, ld_obs.size() - l0, bad, n);
    else n_pass++;
    n_chk++;
    if (max_infl > FD || err_o !== 1'b0 || stab_err != s0)
      $display("FAIL %s_credit got infl=%0d err=%b unstable=%0d want <=%0d 0 0",
               nm, max_infl, err_o, stab_err - s0, FD);
    else n_pass++;
  endtask

  task automatic test_ld_stall;
    logic [AW-1:0] base;
    int a0, l0, d0, early;
    base = $urandom;
    lat_min = 2; lat_max = 2; ar_rand = 0; ld_mode = 1;
    a0 = ar_obs.size(); l0 = ld_obs.size(); d0 = done_cnt;
    send_cmd(0, base, 6);
    early = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk); #1;
      if (c >= 6 && ar_valid_o) early++;
    end
    n_chk++;
    if (ar_obs.size() - a0 != FD || early != 0)
      $display("FAIL stall_ar got %0d issues, %0d valid cycles want %0d 0",
               ar_obs.size() - a0, early, FD);
    else n_pass++;
    n_chk++;
    if (ld_valid_o !== 1'b1 || ld_obs.size() != l0)
      $display("FAIL stall_hold got ld_valid=%b pops=%0d want 1 0",
               ld_valid_o, ld_obs.size() - l0);
    else n_pass++;
    ld_mode = 0;
    wait_done(d0);
    n_chk++;
    if (ar_obs.size() - a0 != 6 || ld_obs.size() - l0 != 6 ||
        ld_obs[l0+5] !== row(base + 32'd5) || err_o !== 1'b0)
      $display("FAIL stall_resume got ar=%0d rows=%0d err=%b want 6 6 0",
               ar_obs.size() - a0, ld_obs.size() - l0, err_o);
    else n_pass++;
  endtask

  task automatic test_store(input string nm, input logic [AW-1:0] base,
                            input int n);
    logic [SW-1:0] d[$];
    int a0, d0, i, t, bad;
    for (int k = 0; k < n; k++) d.push_back(rnd_w());
    a0 = awa_obs.size(); d0 = done_cnt;
    st_valid_i = 0;
    send_cmd(1, base, n);
    i = 0; t = 0;
    while (i < n && t < 500) begin
      @(negedge clk); t++;
      aw_ready_i = 1'($urandom_range(0, 1));
      st_valid_i = $urandom_range(0, 2) != 0;
      st_data_i  = d[i];
      #1;
      if (st_valid_i && st_ready_o) i++;
    end
    @(negedge clk);
    st_valid_i = 0;
    aw_ready_i = 1;
    wait_done(d0);
    bad = -1;
    if (awa_obs.size() - a0 != n) bad = n;
    else for (int k = n - 1; k >= 0; k--)
      if (awa_obs[a0+k] !== base + 32'(k) || awd_obs[a0+k] !== d[k])
        bad = k;
    n_chk++;
    if (bad >= 0)
      $display("FAIL %s_aw got %0d beats (bad idx %0d) want %0d from %h",
               nm, awa_obs.size() - a0, bad, n, base);
    else n_pass++;
    n_chk++;
    if (done_cnt - d0 != 1 || done_q[$] - last_aw != 1)
      $display("FAIL %s_done got %0d pulses lag %0d want 1 1",
               nm, done_cnt - d0, done_q[$] - last_aw);
    else n_pass++;
  endtask

  task automatic test_zero_len;
    int a0, w0, d0;
    for (int op = 0; op < 2; op++) begin
      a0 = ar_obs.size(); w0 = awa_obs.size(); d0 = done_cnt;
      st_valid_i = 1;
      send_cmd(1'(op), 32'h40, 0);
      wait_done(d0);
      st_valid_i = 0;
      n_chk++;
      if (ar_obs.size() != a0 || awa_obs.size() != w0 ||
          done_cnt - d0 != 1 || done_q[$] - hs_q[$] != 2)
        $display("FAIL zero_len_op%0d got ar=%0d aw=%0d done=%0d lag=%0d want 0 0 1 2",
                 op, ar_obs.size() - a0, awa_obs.size() - w0,
                 done_cnt - d0, done_q[$] - hs_q[$]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int a0, t;
    lat_min = 3; lat_max = 3; ar_rand = 0; ld_mode = 1;
    a0 = ar_obs.size();
    send_cmd(0, 32'h200, 8);
    t = 0;
    while (ar_obs.size() - a0 < 3 && t < 100) begin
      @(negedge clk); t++;
    end
    rst_n = 0;
    #1;
    n_chk++;
    if (cmd_ready_o !== 1'b1 || r_ready_o !== 1'b1 ||
        {done_o, ld_valid_o, ar_valid_o, aw_valid_o, st_ready_o, err_o}
        !== 6'b0 || ar_addr_o !== '0 || ld_data_o !== '0)
      $display("FAIL mid_reset got rdy=%b ctl=%b ar=%h ld=%h want 1 0 0 0",
               cmd_ready_o,
               {done_o, ld_valid_o, ar_valid_o, aw_valid_o,
                st_ready_o, err_o}, ar_addr_o, ld_data_o);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    test_load("post_reset", 32'h300, 2, 1, 3, 0, 0);
  endtask

  task automatic test_back_to_back;
    logic [SW-1:0] d[$];
    int h0, q0, a0, l0, w0, d0, i, t;
    bit acc;
    for (int k = 0; k < 3; k++) d.push_back(rnd_w());
    lat_min = 2; lat_max = 2; ar_rand = 0; ld_mode = 0;
    h0 = hs_q.size(); q0 = done_q.size(); a0 = ar_obs.size();
    l0 = ld_obs.size(); w0 = awa_obs.size(); d0 = done_cnt;
    send_cmd(0, 32'h500, 5);
    @(negedge clk);
    cmd_valid_i = 1; cmd_op_i = 1; cmd_addr_i = 32'h900; cmd_len_i = 3;
    aw_ready_i = 1;
    i = 0; t = 0; acc = 0;
    while (i < 3 && t < 600) begin
      @(negedge clk); t++;
      if (acc) cmd_valid_i = 0;
      st_valid_i = 1;
      st_data_i  = d[i];
      #1;
      if (cmd_valid_i && cmd_ready_o) acc = 1;
      if (st_valid_i && st_ready_o) i++;
    end
    @(negedge clk);
    st_valid_i = 0; cmd_valid_i = 0;
    wait_done(d0 + 1);
    n_chk++;
    if (hs_q.size() - h0 != 2 || done_q.size() - q0 != 2 ||
        hs_q[h0+1] <= done_q[q0])
      $display("FAIL b2b_order got hs=%0d done=%0d accept@%0d done@%0d",
               hs_q.size() - h0, done_q.size() - q0,
               hs_q[hs_q.size()-1], done_q[q0]);
    else n_pass++;
    n_chk++;
    if (ld_obs.size() - l0 != 5 || ld_obs[l0+4] !== row(32'h504) ||
        ar_obs.size() - a0 != 5)
      $display("FAIL b2b_load got rows=%0d ar=%0d want 5 5",
               ld_obs.size() - l0, ar_obs.size() - a0);
    else n_pass++;
    n_chk++;
    if (awa_obs.size() - w0 != 3 || awd_obs[w0] !== d[0] ||
        awd_obs[w0+2] !== d[2] || awa_obs[w0+2] !== 32'h902)
      $display("FAIL b2b_store got beats=%0d d0=%h want 3 %h",
               awa_obs.size() - w0, awd_obs[w0], d[0]);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    test_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    test_load("ld8", 32'h10, 8, 2, 2, 0, 0);
    test_ld_stall();
    test_store("st_wrap", 32'hFFFF_FFFE, 4);
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    for (int k = 0; k < 4; k++)
      test_load("ld_rnd", $urandom, $urandom_range(1, 12), 1, 4, 1, 2);
    for (int k = 0; k < 2; k++)
      test_store("st_rnd", $urandom, $urandom_range(1, 9));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
